pll_phase_ctrl: RTL

- Supervisor and dynamic phase-shift sequencer for a multi-output fractional PLL. The SDRAM clock pair is one such PLL.
- Sequences PLL reset and lock qualification.
- Accepts host requests to shift a selected output by N phase steps and drives the PLL dynamic-phase interface one step at a time.
- Tracks a signed accumulated offset per channel and recovers automatically from lock loss.

---
 rtl/pll_phase_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_phase_ctrl.sv
// PLL supervisor: reset sequencing, lock qualification, dynamic phase stepping
// and per-channel signed offset tracking with automatic lock-loss recovery.
module pll_phase_ctrl #(
  parameter int NUM_CH       = 5,
  parameter int CNTSEL_W     = 5,
  parameter int STEP_W       = 10,
  parameter int OFS_W        = 12,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int EN_CYCLES    = 2,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                refclk,
  input  logic                rst,
  output logic                pll_rst,
  input  logic                pll_locked,
  output logic                phase_en,
  output logic                updn,
  output logic [CNTSEL_W-1:0] cntsel,
  input  logic                phase_done,
  output logic                ready,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CNTSEL_W-1:0] req_ch,
  input  logic                req_dir,
  input  logic [STEP_W-1:0]   req_steps,
  output logic                resp_valid,
  output logic                resp_err,
  input  logic [CNTSEL_W-1:0] ofs_ch,
  output logic [OFS_W-1:0]    ofs_val,
  output logic                lock_lost
);

  localparam int CNT_W = $clog2(LOCK_STABLE + RST_CYCLES + EN_CYCLES + 1);
  localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNTSEL_W-1:0] NUM_CH_C = CNTSEL_W'(NUM_CH);

  typedef enum logic [2:0] {
    S_RESET_PLL, S_WAIT_LOCK, S_IDLE, S_STEP, S_WAIT_LO, S_WAIT_HI, S_GAP
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [TO_W-1:0]       r_to;
  logic [STEP_W-1:0]     r_rem;
  logic [CNTSEL_W-1:0]   r_ch;
  logic                  r_dir;
  logic                  r_pll_rst;
  logic                  r_phase_en;
  logic                  r_ready;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic                  r_lock_lost;
  logic                  r_lo1;
  logic [OFS_W-1:0]      r_ofs [NUM_CH];
  logic [OFS_W-1:0]      r_ofs_val;
  logic [OFS_W-1:0]      w_ofs_rd;
  logic                  w_accept;
  logic                  w_lock_loss;
  logic                  w_busy;

  assign w_accept    = req_valid & r_req_ready;
  // A single low sample is a glitch; two in a row while qualified is a real loss.
  assign w_lock_loss = r_ready & ~pll_locked & r_lo1;
  assign w_busy      = (r_state == S_STEP) || (r_state == S_WAIT_LO) ||
                       (r_state == S_WAIT_HI) || (r_state == S_GAP);

  // Main sequencer: reset/lock qualification, request handling, stepping, offsets.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      r_to         <= '0;
      r_rem        <= '0;
      r_ch         <= '0;
      r_dir        <= 1'b0;
      r_pll_rst    <= 1'b1;
      r_phase_en   <= 1'b0;
      r_ready      <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_lo1        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_ofs[i] <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_lo1        <= ~pll_locked;
      if (w_lock_loss) begin
        r_lock_lost <= 1'b1;
        r_ready     <= 1'b0;
        r_req_ready <= 1'b0;
        r_phase_en  <= 1'b0;
        r_pll_rst   <= 1'b1;
        r_cnt       <= '0;
        r_to        <= '0;
        r_state     <= S_RESET_PLL;
        if (w_busy || w_accept) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) r_ofs[i] <= '0;
      end else begin
        case (r_state)
          S_RESET_PLL: begin
            if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
              r_pll_rst <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_WAIT_LOCK;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (!pll_locked) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_IDLE: begin
            if (!r_ready) begin
              r_ready     <= 1'b1;
              r_req_ready <= 1'b1;
            end else if (w_accept) begin
              r_ch  <= req_ch;
              r_dir <= req_dir;
              r_rem <= req_steps;
              if (req_ch >= NUM_CH_C) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
              end else if (req_steps == STEP_W'(0)) begin
                r_resp_valid <= 1'b1;
              end else begin
                r_req_ready <= 1'b0;
                r_phase_en  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= S_STEP;
              end
            end
          end
          S_STEP: begin
            if (r_cnt == CNT_W'(EN_CYCLES - 1)) begin
              r_phase_en <= 1'b0;
              r_to       <= '0;
              r_state    <= S_WAIT_LO;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_WAIT_LO, S_WAIT_HI: begin
            if ((r_state == S_WAIT_HI) && phase_done) begin
              r_rem <= r_rem - STEP_W'(1);
              for (int i = 0; i < NUM_CH; i++) begin
                if (r_ch == CNTSEL_W'(i))
                  r_ofs[i] <= r_dir ? (r_ofs[i] + OFS_W'(1)) : (r_ofs[i] - OFS_W'(1));
              end
              if (r_rem == STEP_W'(1)) begin
                r_resp_valid <= 1'b1;
                r_req_ready  <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_GAP;
              end
            end else if (r_to == TO_W'(DONE_TIMEOUT - 1)) begin
              // Step never completed: abort without counting it.
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_req_ready  <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_to <= r_to + TO_W'(1);
              if ((r_state == S_WAIT_LO) && !phase_done) r_state <= S_WAIT_HI;
            end
          end
          S_GAP: begin
            r_phase_en <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_STEP;
          end
          default: begin
            r_state     <= S_RESET_PLL;
            r_pll_rst   <= 1'b1;
            r_phase_en  <= 1'b0;
            r_ready     <= 1'b0;
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
          end
        endcase
      end
    end
  end

  // Offset read mux; out-of-range channels read as zero.
  always_comb begin
    w_ofs_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ofs_ch == CNTSEL_W'(i)) w_ofs_rd = r_ofs[i];
    end
  end

  // Registered offset readback.
  always_ff @(posedge refclk) begin
    if (rst) r_ofs_val <= '0;
    else     r_ofs_val <= w_ofs_rd;
  end

  assign pll_rst    = r_pll_rst;
  assign phase_en   = r_phase_en;
  assign updn       = r_dir;
  assign cntsel     = r_ch;
  assign ready      = r_ready;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign ofs_val    = r_ofs_val;
  assign lock_lost  = r_lock_lost;

endmodule
